// File: rtl/bus_pkg.sv
// Shared system-bus definitions: slave select encoding and the address
// decoder FSM state type.
package bus_pkg;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_S1   = 2'b01;
    localparam logic [1:0] SEL_S2   = 2'b10;
    localparam logic [1:0] SEL_S3   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } bus_state_t;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Clear/enable saturating cycle counter; tc flags a count of TIMEOUT-1.
module bus_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == TC_VAL);

    // Holds at the terminal value instead of wrapping back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bus_addr_decoder.sv
// Master-side address decoder: decodes the top address bits into a slave
// select, strobes the slave once and reports done / error / timeout.
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_req,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic              m_wr,
    input  logic              bus_ready,
    output logic [1:0]        select,
    output logic              s_valid,
    output logic [ADDR_W-3:0] s_addr,
    output logic              s_wr,
    output logic              busy,
    output logic              m_done,
    output logic              m_err
);

    // Handshake: the master holds m_req until busy is seen high; a request is
    // taken only at an IDLE edge. s_valid is a single-cycle strobe with select
    // held until bus_ready (registered, one cycle late) is seen in WAIT;
    // bus_ready is not looked at in any other state.

    bus_state_t        state, state_next;
    logic [1:0]        select_next;
    logic              s_valid_next;
    logic [ADDR_W-3:0] s_addr_next;
    logic              s_wr_next;
    logic              busy_next;
    logic              m_done_next;
    logic              m_err_next;
    logic              tc;
    logic [1:0]        addr_sel;

    assign addr_sel = m_addr[ADDR_W-1 -: 2];

    bus_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state == ST_ISSUE),
        .en   (state == ST_WAIT),
        .tc   (tc)
    );

    always_comb begin
        state_next   = state;
        select_next  = select;
        s_valid_next = 1'b0;
        s_addr_next  = s_addr;
        s_wr_next    = s_wr;

        case (state)
            ST_IDLE: begin
                select_next = SEL_NONE;
                if (m_req) begin
                    s_addr_next = m_addr[ADDR_W-3:0];
                    s_wr_next   = m_wr;
                    if (addr_sel == SEL_NONE) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next   = ST_ISSUE;
                        select_next  = addr_sel;
                        s_valid_next = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion takes priority over a timeout on the same edge.
                if (bus_ready) begin
                    state_next  = ST_DONE;
                    select_next = SEL_NONE;
                end else if (tc) begin
                    state_next  = ST_ERR;
                    select_next = SEL_NONE;
                end
            end
            ST_DONE, ST_ERR: begin
                state_next  = ST_IDLE;
                select_next = SEL_NONE;
            end
            default: begin
                state_next  = ST_IDLE;
                select_next = SEL_NONE;
            end
        endcase

        busy_next   = (state_next != ST_IDLE);
        m_done_next = (state_next == ST_DONE);
        m_err_next  = (state_next == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            select  <= SEL_NONE;
            s_valid <= 1'b0;
            s_addr  <= '0;
            s_wr    <= 1'b0;
            busy    <= 1'b0;
            m_done  <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            state   <= state_next;
            select  <= select_next;
            s_valid <= s_valid_next;
            s_addr  <= s_addr_next;
            s_wr    <= s_wr_next;
            busy    <= busy_next;
            m_done  <= m_done_next;
            m_err   <= m_err_next;
        end
    end

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Directed bench for bus_addr_decoder: reset, decode, unmapped, timeout,
// back-to-back requests and mid-transaction reset.
module tb_bus_addr_decoder;

    localparam int ADDR_W  = 14;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              rst_n;
    logic              m_req;
    logic [ADDR_W-1:0] m_addr;
    logic              m_wr;
    logic              bus_ready;
    logic [1:0]        select;
    logic              s_valid;
    logic [ADDR_W-3:0] s_addr;
    logic              s_wr;
    logic              busy;
    logic              m_done;
    logic              m_err;

    int checks;
    int fails;

    // {select, s_valid, s_wr, busy, m_done, m_err}
    logic [6:0] obs;
    assign obs = {select, s_valid, s_wr, busy, m_done, m_err};

    bus_addr_decoder #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_wr     (m_wr),
        .bus_ready(bus_ready),
        .select   (select),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wr     (s_wr),
        .busy     (busy),
        .m_done   (m_done),
        .m_err    (m_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m_req = 1'b0; m_addr = '0; m_wr = 1'b0; bus_ready = 1'b0;
        tick(); tick();
        checks++;
        if (obs !== 7'b00_0_0_0_0_0) begin
            fails++; $display("FAIL reset_outputs: got %b want %b", obs, 7'b0);
        end
        checks++;
        if (s_addr !== 12'h000) begin
            fails++; $display("FAIL reset_s_addr: got %h want 000", s_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0) begin
                fails++; $display("FAIL idle_busy[%0d]: got %b want 0", i, busy);
            end
        end
    endtask

    task automatic test_write_s2();
        m_addr = 14'h2ABC; m_wr = 1'b1; m_req = 1'b1; bus_ready = 1'b0;
        tick();
        m_req = 1'b0;
        checks++;
        if (obs !== 7'b10_1_1_1_0_0) begin
            fails++; $display("FAIL wr_issue: got %b want %b", obs, 7'b10_1_1_1_0_0);
        end
        checks++;
        if (s_addr !== 12'hABC) begin
            fails++; $display("FAIL wr_s_addr: got %h want abc", s_addr);
        end
        tick();
        checks++;
        if (obs !== 7'b10_0_1_1_0_0) begin
            fails++; $display("FAIL wr_wait1: got %b want %b", obs, 7'b10_0_1_1_0_0);
        end
        tick();
        bus_ready = 1'b1;
        checks++;
        if (obs !== 7'b10_0_1_1_0_0) begin
            fails++; $display("FAIL wr_wait2: got %b want %b", obs, 7'b10_0_1_1_0_0);
        end
        tick();
        bus_ready = 1'b0;
        checks++;
        if (obs !== 7'b00_0_1_1_1_0) begin
            fails++; $display("FAIL wr_done: got %b want %b", obs, 7'b00_0_1_1_1_0);
        end
        tick();
        checks++;
        if (obs !== 7'b00_0_1_0_0_0) begin
            fails++; $display("FAIL wr_idle: got %b want %b", obs, 7'b00_0_1_0_0_0);
        end
    endtask

    task automatic test_unmapped();
        m_addr = 14'h0123; m_wr = 1'b0; m_req = 1'b1; bus_ready = 1'b0;
        tick();
        m_req = 1'b0;
        checks++;
        if (obs !== 7'b00_0_0_1_0_1) begin
            fails++; $display("FAIL unmapped_err: got %b want %b", obs, 7'b00_0_0_1_0_1);
        end
        checks++;
        if (s_addr !== 12'h123) begin
            fails++; $display("FAIL unmapped_s_addr: got %h want 123", s_addr);
        end
        tick();
        checks++;
        if (obs !== 7'b00_0_0_0_0_0) begin
            fails++; $display("FAIL unmapped_idle: got %b want %b", obs, 7'b0);
        end
    endtask

    // late_ready = 1 raises bus_ready for the final WAIT edge only.
    task automatic test_timeout(input logic late_ready);
        m_addr = 14'h1F00; m_wr = 1'b0; m_req = 1'b1; bus_ready = 1'b0;
        tick();
        m_req = 1'b0;
        checks++;
        if (obs !== 7'b01_1_0_1_0_0) begin
            fails++; $display("FAIL to_issue(%0d): got %b want %b", late_ready, obs, 7'b01_1_0_1_0_0);
        end
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            checks++;
            if (obs !== 7'b01_0_0_1_0_0) begin
                fails++; $display("FAIL to_wait(%0d)[%0d]: got %b want %b", late_ready, i, obs, 7'b01_0_0_1_0_0);
            end
            if (i == TIMEOUT - 1) bus_ready = late_ready;
        end
        tick();
        bus_ready = 1'b0;
        checks++;
        if (late_ready) begin
            if (obs !== 7'b00_0_0_1_1_0) begin
                fails++; $display("FAIL to_late_done: got %b want %b", obs, 7'b00_0_0_1_1_0);
            end
        end else begin
            if (obs !== 7'b00_0_0_1_0_1) begin
                fails++; $display("FAIL to_err: got %b want %b", obs, 7'b00_0_0_1_0_1);
            end
        end
        tick();
        checks++;
        if (obs !== 7'b00_0_0_0_0_0) begin
            fails++; $display("FAIL to_idle(%0d): got %b want %b", late_ready, obs, 7'b0);
        end
    endtask

    task automatic test_back_to_back();
        m_addr = 14'h3001; m_wr = 1'b1; m_req = 1'b1; bus_ready = 1'b0;
        tick();
        m_addr = 14'h1002; m_wr = 1'b0;
        checks++;
        if (obs !== 7'b11_1_1_1_0_0) begin
            fails++; $display("FAIL b2b_issue1: got %b want %b", obs, 7'b11_1_1_1_0_0);
        end
        tick();
        bus_ready = 1'b1;
        checks++;
        if (obs !== 7'b11_0_1_1_0_0) begin
            fails++; $display("FAIL b2b_wait1: got %b want %b", obs, 7'b11_0_1_1_0_0);
        end
        tick();
        bus_ready = 1'b0;
        checks++;
        if (obs !== 7'b00_0_1_1_1_0) begin
            fails++; $display("FAIL b2b_done1: got %b want %b", obs, 7'b00_0_1_1_1_0);
        end
        tick();
        checks++;
        if (obs !== 7'b00_0_1_0_0_0) begin
            fails++; $display("FAIL b2b_gap: got %b want %b", obs, 7'b00_0_1_0_0_0);
        end
        tick();
        m_req = 1'b0;
        checks++;
        if (obs !== 7'b01_1_0_1_0_0) begin
            fails++; $display("FAIL b2b_issue2: got %b want %b", obs, 7'b01_1_0_1_0_0);
        end
        checks++;
        if (s_addr !== 12'h002) begin
            fails++; $display("FAIL b2b_s_addr2: got %h want 002", s_addr);
        end
        tick();
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        checks++;
        if (obs !== 7'b00_0_0_1_1_0) begin
            fails++; $display("FAIL b2b_done2: got %b want %b", obs, 7'b00_0_0_1_1_0);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        m_addr = 14'h2ABC; m_wr = 1'b1; m_req = 1'b1; bus_ready = 1'b0;
        tick();
        m_req = 1'b0;
        tick(); tick();
        checks++;
        if (obs !== 7'b10_0_1_1_0_0) begin
            fails++; $display("FAIL mid_pre_wait: got %b want %b", obs, 7'b10_0_1_1_0_0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 7'b00_0_0_0_0_0) begin
            fails++; $display("FAIL mid_async_reset: got %b want %b", obs, 7'b0);
        end
        checks++;
        if (s_addr !== 12'h000) begin
            fails++; $display("FAIL mid_s_addr: got %h want 000", s_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== 7'b00_0_0_0_0_0) begin
            fails++; $display("FAIL mid_post_idle: got %b want %b", obs, 7'b0);
        end
        m_addr = 14'h3055; m_wr = 1'b1; m_req = 1'b1;
        tick();
        m_req = 1'b0;
        checks++;
        if (obs !== 7'b11_1_1_1_0_0 || s_addr !== 12'h055) begin
            fails++; $display("FAIL mid_reissue: got %b/%h want %b/055", obs, s_addr, 7'b11_1_1_1_0_0);
        end
        tick();
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        checks++;
        if (obs !== 7'b00_0_1_1_1_0) begin
            fails++; $display("FAIL mid_done: got %b want %b", obs, 7'b00_0_1_1_1_0);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_write_s2();
        test_unmapped();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bus_addr_decoder.md
Name: bus_addr_decoder

Overview:
Upstream neighbour of the slave ready multiplexer in the system bus. It accepts one master request at a time and decodes the top address bits into the 2-bit slave select. It holds that select stable for the whole transaction and issues a one-cycle slave strobe. It then waits for the registered bus_ready that the ready mux returns, and reports completion, unmapped-address error, or timeout to the master.

Parameters:
ADDR_W, 14, master address width; bits [ADDR_W-1:ADDR_W-2] select the slave, the remaining bits are the slave-local address.
TIMEOUT, 16, number of WAIT cycles without bus_ready before the transaction is aborted (legal range 2..255).

Ports:
clk  in  1  bus clock
rst_n  in  1  asynchronous active-low reset
m_req  in  1  master request, sampled only in IDLE
m_addr  in  ADDR_W  master address, sampled with m_req
m_wr  in  1  1 = write, 0 = read, sampled with m_req
bus_ready  in  1  registered ready from the ready mux (one-cycle lag; may be X when select = 00)
select  out  2  slave select: 00 none, 01 S1, 10 S2, 11 S3
s_valid  out  1  one-cycle strobe: address and command valid to the selected slave
s_addr  out  ADDR_W-2  latched slave-local address
s_wr  out  1  latched write flag
busy  out  1  high in every state except IDLE
m_done  out  1  one-cycle pulse: transaction completed
m_err  out  1  one-cycle pulse: unmapped address or timeout

Behaviour:
- Reset: asynchronous and active-low, effective immediately, including mid-transaction. While rst_n = 0: state IDLE, select = 00, s_valid = 0, s_addr = 0, s_wr = 0, busy = 0, m_done = 0, m_err = 0, timeout counter = 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE:
  - Acceptance occurs at a rising edge with m_req = 1. It latches m_addr[ADDR_W-3:0] into s_addr and m_wr into s_wr.
  - If m_addr[ADDR_W-1:ADDR_W-2] == 00, the next state is ERR and select stays 00.
  - Otherwise the next state is ISSUE and select takes the top two address bits.
- ISSUE (exactly 1 cycle): s_valid = 1, select valid, next state WAIT, counter cleared. bus_ready is ignored here because it still reflects the previous select.
- WAIT:
  - s_valid = 0, select held, counter increments each cycle.
  - bus_ready == 1 at an edge: next state DONE.
  - Counter reaches TIMEOUT-1 with bus_ready == 0: next state ERR.
  - If bus_ready == 1 on the same edge as the timeout, completion wins and the next state is DONE.
- DONE (1 cycle): m_done = 1, select = 00, next state IDLE.
- ERR (1 cycle): m_err = 1, select = 00, next state IDLE.
- bus_ready is sampled only in WAIT. An X on bus_ready in any other state must not propagate into the state or outputs.
- m_req is ignored while busy; there is no queueing. The master holds m_req until it sees busy high. A request held through DONE/ERR is re-accepted on the first IDLE edge.
- Latency, with acceptance at edge k:
  - s_valid and select are valid in cycle k+1.
  - The earliest m_done is cycle k+3, when the slave is ready immediately.
  - An unmapped address gives m_err in cycle k+1.
  - A timeout gives m_err TIMEOUT+2 cycles after acceptance.
- Counter width is $clog2(TIMEOUT); it saturates and never wraps.

Decomposition:
- Shared package bus_pkg:
  - slave select constants SEL_NONE = 2'b00, SEL_S1 = 2'b01, SEL_S2 = 2'b10, SEL_S3 = 2'b11 (shared with the ready mux and the data muxes);
  - FSM state enum.
- One natural sub-module: bus_timeout_cnt, a clear/enable saturating counter with a terminal-count flag at TIMEOUT-1.

Test Plan:
1. Reset check: assert rst_n = 0 -> all outputs 0 and select = 00. Release rst_n, hold m_req = 0 for 5 cycles -> busy stays 0.
2. Write to S2: m_addr = 14'h2ABC, m_wr = 1, bus_ready = 1 from the second WAIT edge -> in cycle k+1 select = 10, s_addr = 12'hABC, s_wr = 1, s_valid = 1. m_done pulses once in cycle k+4 and select returns to 00.
3. Unmapped address: m_addr = 14'h0123 -> m_err = 1 in cycle k+1 only, s_valid never asserts, select stays 00.
4. Timeout: read to 14'h1F00 with bus_ready held at 0 -> select = 01 for the ISSUE cycle plus 16 WAIT cycles, then m_err pulses and select = 00. Also: bus_ready rising on the final WAIT edge -> m_done, not m_err.
5. Back-to-back: m_req held high with S3 address 14'h3001 and then S1 address 14'h1002 -> second acceptance on the IDLE edge after DONE. select goes 11 -> 00 -> 01 with no overlap.
6. Reset mid-transaction: drop rst_n in WAIT between clock edges -> select, s_valid, and busy go to 0 immediately. After release the FSM is in IDLE and accepts a new request normally.
